acog_writeback: RTL and testbench

//  Result/flag commit stage directly downstream of the cog ALU sum unit (SUMC/SUMNC/SUMZ/SUMNZ).
//  - Takes the ALU result q, its carry/overflow flag and the instruction's control bits.
//  - Evaluates the instruction's 4-bit condition against the architectural C/Z flags.
//  - Commits the C/Z flags, which feed straight back to the ALU flag_c_in/flag_z_in.
//  - Drives the cog-RAM write port through a one-deep buffer with a write-acknowledge handshake.

---
 rtl/acog_writeback_pkg.sv | 17 +
 rtl/acog_writeback_if.sv | 29 ++
 rtl/acog_writeback_cond_eval.sv | 9 +
 rtl/acog_writeback.sv | 90 +++++++++
 tb/tb_acog_writeback.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/acog_writeback_pkg.sv
// Shared definitions for the cog writeback stage: FSM states and condition-field constants.
package acog_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wb_state_e;

  // Condition field is a truth table indexed by {C,Z}.
  localparam logic [3:0] IF_NEVER  = 4'h0;
  localparam logic [3:0] IF_ALWAYS = 4'hF;
  localparam logic [3:0] IF_C      = 4'hC;
  localparam logic [3:0] IF_NC     = 4'h3;
  localparam logic [3:0] IF_Z      = 4'hA;
  localparam logic [3:0] IF_NZ     = 4'h5;

endpackage

// File: rtl/acog_writeback_if.sv
// Issue-side handshake plus cog-RAM write port of the writeback stage.
interface acog_writeback_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic              valid_in;
  logic              ready_o;
  logic [3:0]        cond_in;
  logic              wc_in;
  logic              wz_in;
  logic              wr_in;
  logic [ADDR_W-1:0] d_addr_in;
  logic [DATA_W-1:0] q_in;
  logic              flag_c_in;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              wr_ack_in;

  modport master (
    output valid_in, cond_in, wc_in, wz_in, wr_in, d_addr_in, q_in, flag_c_in, wr_ack_in,
    input  ready_o, wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  valid_in, cond_in, wc_in, wz_in, wr_in, d_addr_in, q_in, flag_c_in, wr_ack_in,
    output ready_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/acog_writeback_cond_eval.sv
// Condition evaluator: selects the cond bit addressed by the current {C,Z} flags.
module acog_cond_eval (
  input  logic [3:0] cond,
  input  logic       c,
  input  logic       z,
  output logic       exec
);
  assign exec = cond[{c, z}];
endmodule

// File: rtl/acog_writeback.sv
// Cog ALU result/flag commit stage with a one-deep cog-RAM write buffer.
// Optional ACOG_WB_BYPASS_EN exposes the pending write for operand forwarding.
module acog_writeback
  import acog_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk_in,
  input  logic                 reset_n_in,
  acog_writeback_if.slave      wb,
  output logic                 flag_c_o,
  output logic                 flag_z_o,
  output logic [CNT_W-1:0]     retire_cnt_o
`ifdef ACOG_WB_BYPASS_EN
  ,
  output logic                 bypass_valid_o,
  output logic [ADDR_W-1:0]    bypass_addr_o,
  output logic [DATA_W-1:0]    bypass_data_o
`endif
);

  wb_state_e state_q, state_d;
  logic      exec;
  logic      transfer;
  logic      load_buf;

  acog_cond_eval u_cond_eval (
    .cond (wb.cond_in),
    .c    (flag_c_o),
    .z    (flag_z_o),
    .exec (exec)
  );

  // An ack in WRITE both retires the buffered write and frees the slot for
  // a same-cycle transfer, so a new writing result reloads without a bubble.
  always_comb begin
    state_d    = state_q;
    wb.ready_o = 1'b0;
    load_buf   = 1'b0;
    case (state_q)
      ST_IDLE:  wb.ready_o = 1'b1;
      ST_WRITE: begin
        wb.ready_o = wb.wr_ack_in;
        if (wb.wr_ack_in) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
    transfer = wb.valid_in & wb.ready_o;
    if (transfer && exec && wb.wr_in) begin
      load_buf = 1'b1;
      state_d  = ST_WRITE;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      flag_c_o     <= 1'b0;
      flag_z_o     <= 1'b0;
      retire_cnt_o <= '0;
      wb.wr_addr_o <= '0;
      wb.wr_data_o <= '0;
    end else begin
      if (transfer && exec) begin
        retire_cnt_o <= retire_cnt_o + 1'b1;
        if (wb.wc_in) flag_c_o <= wb.flag_c_in;
        if (wb.wz_in) flag_z_o <= (wb.q_in == '0);
      end
      if (load_buf) begin
        wb.wr_addr_o <= wb.d_addr_in;
        wb.wr_data_o <= wb.q_in;
      end
    end
  end

  assign wb.wr_en_o = (state_q == ST_WRITE);

`ifdef ACOG_WB_BYPASS_EN
  assign bypass_valid_o = wb.wr_en_o;
  assign bypass_addr_o  = wb.wr_addr_o;
  assign bypass_data_o  = wb.wr_data_o;
`endif

endmodule

// File: tb/tb_acog_writeback.sv
// Scoreboard bench for acog_writeback: driver updates a flag/counter model and queues
// expected writes and flag states; a monitor pops and compares as the DUT presents them.
module tb_acog_writeback;
  import acog_pkg::*;

  typedef struct { logic c; logic z; logic [15:0] cnt; } fexp_t;
  typedef struct { logic [8:0] a; logic [31:0] d; } wexp_t;

  logic clk, rst_n;
  acog_writeback_if #(.ADDR_W(9), .DATA_W(32)) wb ();
  logic        flag_c, flag_z;
  logic [15:0] retire_cnt;
`ifdef ACOG_WB_BYPASS_EN
  logic        bypass_valid;
  logic [8:0]  bypass_addr;
  logic [31:0] bypass_data;
`endif

  acog_writeback #(.ADDR_W(9), .DATA_W(32), .CNT_W(16)) dut (
    .clk_in       (clk),
    .reset_n_in   (rst_n),
    .wb           (wb),
    .flag_c_o     (flag_c),
    .flag_z_o     (flag_z),
    .retire_cnt_o (retire_cnt)
`ifdef ACOG_WB_BYPASS_EN
    ,
    .bypass_valid_o (bypass_valid),
    .bypass_addr_o  (bypass_addr),
    .bypass_data_o  (bypass_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  int    ack_mode = 0;   // 0: never ack, 1: random ack, 2: always ack
  fexp_t fq[$];
  wexp_t wq[$];
  fexp_t cur;
  logic  mc, mz;
  logic [15:0] mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    case (ack_mode)
      0:       wb.wr_ack_in = 1'b0;
      2:       wb.wr_ack_in = 1'b1;
      default: wb.wr_ack_in = ($urandom_range(0, 2) != 0);
    endcase
  end

  // Monitor: pre-edge handshake sampling, post-edge state comparison.
  always @(posedge clk) begin
    logic  tx, wack;
    wexp_t w;
    if (rst_n) begin
      tx   = wb.valid_in & wb.ready_o;
      wack = wb.wr_en_o & wb.wr_ack_in;
      chk("ready_rule", {31'd0, wb.ready_o}, {31'd0, (!wb.wr_en_o) | wb.wr_ack_in});
      if (wack) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", {23'd0, wb.wr_addr_o}, {23'd0, w.a});
          chk("wr_data", wb.wr_data_o, w.d);
        end
      end
      #1;
      if (tx) begin
        if (fq.size() == 0) chk("unexpected_transfer", 32'd1, 32'd0);
        else cur = fq.pop_front();
      end
      chk("flag_c", {31'd0, flag_c}, {31'd0, cur.c});
      chk("flag_z", {31'd0, flag_z}, {31'd0, cur.z});
      chk("retire_cnt", {16'd0, retire_cnt}, {16'd0, cur.cnt});
`ifdef ACOG_WB_BYPASS_EN
      chk("bypass_valid", {31'd0, bypass_valid}, {31'd0, wb.wr_en_o});
      chk("bypass_addr", {23'd0, bypass_addr}, {23'd0, wb.wr_addr_o});
      chk("bypass_data", bypass_data, wb.wr_data_o);
`endif
    end
  end

  // Presents one instruction, holds it until accepted, then applies the model.
  task automatic issue(input logic [3:0] cond, input logic wc, input logic wz, input logic wr,
                       input logic [8:0] addr, input logic [31:0] q, input logic fc);
    int    n = 0;
    logic  ex;
    fexp_t f;
    @(negedge clk);
    wb.cond_in = cond; wb.wc_in = wc; wb.wz_in = wz; wb.wr_in = wr;
    wb.d_addr_in = addr; wb.q_in = q; wb.flag_c_in = fc; wb.valid_in = 1'b1;
    #2;
    while (!wb.ready_o && n < 50) begin
      @(negedge clk); #2; n++;
    end
    if (!wb.ready_o) begin
      chk("ready_timeout", 32'd0, 32'd1);
    end else begin
      ex = cond[{mc, mz}];
      if (ex) begin
        mcnt = mcnt + 16'd1;
        if (wc) mc = fc;
        if (wz) mz = (q == 32'd0);
        if (wr) wq.push_back('{a: addr, d: q});
      end
      f.c = mc; f.z = mz; f.cnt = mcnt;
      fq.push_back(f);
    end
    @(posedge clk); #1;
    wb.valid_in = 1'b0;
  endtask

  task automatic clear_model();
    fq.delete(); wq.delete();
    mc = 1'b0; mz = 1'b0; mcnt = 16'd0;
    cur.c = 1'b0; cur.z = 1'b0; cur.cnt = 16'd0;
  endtask

  initial begin
    logic [3:0] conds [6];
    conds[0] = IF_NEVER; conds[1] = IF_ALWAYS; conds[2] = IF_C;
    conds[3] = IF_NC;    conds[4] = IF_Z;      conds[5] = IF_NZ;
    wb.valid_in = 1'b0; wb.cond_in = '0; wb.wc_in = 1'b0; wb.wz_in = 1'b0; wb.wr_in = 1'b0;
    wb.d_addr_in = '0; wb.q_in = '0; wb.flag_c_in = 1'b0; wb.wr_ack_in = 1'b0;
    clear_model();
    rst_n = 1'b0;
    #3;
    chk("rst_wr_en", {31'd0, wb.wr_en_o}, 32'd0);
    chk("rst_cnt", {16'd0, retire_cnt}, 32'd0);
    #9 rst_n = 1'b1;

    // Flag and write commit one cycle after transfer; write then stalls on no ack.
    ack_mode = 0;
    issue(IF_ALWAYS, 1'b1, 1'b1, 1'b1, 9'h010, 32'd0, 1'b1);
    chk("t2_c", {31'd0, flag_c}, 32'd1);
    chk("t2_z", {31'd0, flag_z}, 32'd1);
    chk("t2_wr_en", {31'd0, wb.wr_en_o}, 32'd1);
    chk("t2_addr", {23'd0, wb.wr_addr_o}, 32'h010);
    chk("t2_data", wb.wr_data_o, 32'd0);
    repeat (3) begin
      @(negedge clk); #2;
      chk("t4_stall_ready", {31'd0, wb.ready_o}, 32'd0);
      chk("t4_hold_data", wb.wr_data_o, 32'd0);
    end
    ack_mode = 2;
    issue(IF_ALWAYS, 1'b0, 1'b0, 1'b1, 9'h020, 32'h7FFF_FFFF, 1'b0);
    chk("t4_reload", wb.wr_data_o, 32'h7FFF_FFFF);

    // Clear flags, then a cond-false instruction must leave everything alone.
    issue(IF_ALWAYS, 1'b1, 1'b1, 1'b0, 9'h000, 32'd1, 1'b0);
    issue(IF_C, 1'b1, 1'b0, 1'b1, 9'h033, 32'h1234, 1'b1);
    chk("t3_c", {31'd0, flag_c}, 32'd0);
    chk("t3_cnt", {16'd0, retire_cnt}, {16'd0, mcnt});
    chk("t3_wr_en", {31'd0, wb.wr_en_o}, 32'd0);
    chk("t3_ready", {31'd0, wb.ready_o}, 32'd1);

    // Back-to-back: second instruction depends on C set by the first.
    issue(IF_ALWAYS, 1'b1, 1'b0, 1'b0, 9'h000, 32'd2, 1'b1);
    issue(IF_C, 1'b0, 1'b1, 1'b0, 9'h000, 32'd0, 1'b0);
    chk("t5_c", {31'd0, flag_c}, 32'd1);
    chk("t5_z", {31'd0, flag_z}, 32'd1);

    ack_mode = 1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] q;
      q = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      issue(conds[$urandom_range(0, 5)], 1'($urandom), 1'($urandom), 1'($urandom),
            9'($urandom), q, 1'($urandom));
    end

    // Counter wrap.
    ack_mode = 2;
    while (mcnt != 16'hFFFF) issue(IF_ALWAYS, 1'b0, 1'b0, 1'b0, 9'h000, 32'd5, 1'b0);
    chk("t6_full", {16'd0, retire_cnt}, 32'h0000_FFFF);
    issue(IF_ALWAYS, 1'b0, 1'b0, 1'b0, 9'h000, 32'd5, 1'b0);
    chk("t6_wrap", {16'd0, retire_cnt}, 32'd0);

    // Asynchronous reset drops a pending write.
    ack_mode = 0;
    issue(IF_ALWAYS, 1'b1, 1'b1, 1'b1, 9'h1AB, 32'd0, 1'b1);
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t1_wr_en", {31'd0, wb.wr_en_o}, 32'd0);
    chk("t1_addr", {23'd0, wb.wr_addr_o}, 32'd0);
    chk("t1_data", wb.wr_data_o, 32'd0);
    chk("t1_c", {31'd0, flag_c}, 32'd0);
    chk("t1_z", {31'd0, flag_z}, 32'd0);
    chk("t1_cnt", {16'd0, retire_cnt}, 32'd0);
    clear_model();
    @(negedge clk); #2 rst_n = 1'b1;
    ack_mode = 2;
    repeat (2) @(posedge clk);
    #2;
    chk("t1_no_replay", {31'd0, wb.wr_en_o}, 32'd0);

    // Drain any outstanding writes.
    ack_mode = 1;
    for (int i = 0; i < 20 && wq.size() != 0; i++) @(posedge clk);
    chk("drain_empty", wq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
